// File: rtl/fault_trap_unit.sv
// Fault trap: records every CPU fault into a circular history, halts the CPU for a hold window, then parks or restarts it.
// Optional macro FAULT_TRACE_EN adds a cycle counter and per-fault simulation trace messages.
module fault_trap_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CAUSE_W      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned AUTO_RESTART = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fault_valid,
    input  logic [31:0]                fault_pc,
    input  logic [CAUSE_W-1:0]         fault_cause,
    input  logic                       clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic                       halt,
    output logic                       restart,
    output logic                       rd_valid,
    output logic [31:0]                rd_pc,
    output logic [CAUSE_W-1:0]         rd_cause,
    output logic [CNT_W-1:0]           fault_cnt,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_RESTART, ST_STOP} state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               halt_nxt, restart_nxt;

    logic [31:0]        pc_mem    [DEPTH];
    logic [CAUSE_W-1:0] cause_mem [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_slot;
    logic               wr_en;

    assign wr_en   = fault_valid & ~clear;
    assign rd_slot = wr_ptr - PTR_W'(1) - rd_idx;

    // State register and hold timer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state logic; clear wins over everything
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        if (clear) begin
            state_nxt = ST_RUN;
            timer_nxt = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (fault_valid) begin
                        state_nxt = ST_HOLD;
                        timer_nxt = TMR_W'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    if (timer == '0) begin
                        state_nxt = (AUTO_RESTART != 0) ? ST_RESTART : ST_STOP;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
                ST_RESTART: state_nxt = ST_RUN;
                ST_STOP:    state_nxt = ST_STOP;
                default:    state_nxt = ST_RUN;
            endcase
        end
    end

    // Output decode from the next state, registered below
    always_comb begin
        halt_nxt    = (state_nxt != ST_RUN);
        restart_nxt = (state_nxt == ST_RESTART);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halt    <= 1'b0;
            restart <= 1'b0;
        end else begin
            halt    <= halt_nxt;
            restart <= restart_nxt;
        end
    end

    // History write side, counter and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            valid_q   <= '0;
            fault_cnt <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                cause_mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr    <= '0;
            valid_q   <= '0;
            fault_cnt <= '0;
            overflow  <= 1'b0;
        end else if (wr_en) begin
            pc_mem[wr_ptr]    <= fault_pc;
            cause_mem[wr_ptr] <= fault_cause;
            valid_q[wr_ptr]   <= 1'b1;
            wr_ptr            <= wr_ptr + PTR_W'(1);
            if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + CNT_W'(1);
            if (valid_q[wr_ptr]) overflow <= 1'b1;
        end
    end

    // Registered readout; sees pre-write contents on a same-cycle write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_cause <= '0;
        end else begin
            rd_valid <= valid_q[rd_slot];
            rd_pc    <= pc_mem[rd_slot];
            rd_cause <= cause_mem[rd_slot];
        end
    end

`ifdef FAULT_TRACE_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cycle_cnt <= '0;
        else         cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            $display("fault cycle=%0d pc=0x%08h cause=%0d slot=%0d",
                     cycle_cnt, fault_pc, fault_cause, wr_ptr);
            if (valid_q[wr_ptr]) $display("fault history overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fault_trap_unit.sv
// Directed bench for fault_trap_unit: instance a (hold 16, park) and instance b (hold 4, auto restart, 2-bit counter).
module tb_fault_trap_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_resetn, a_fv, a_clear;
    logic [31:0] a_pc;
    logic [3:0]  a_cause;
    logic [1:0]  a_idx;
    logic        a_halt, a_restart, a_rd_valid, a_ovf;
    logic [31:0] a_rd_pc;
    logic [3:0]  a_rd_cause;
    logic [7:0]  a_cnt;

    logic        b_resetn, b_fv, b_clear;
    logic [31:0] b_pc;
    logic [3:0]  b_cause;
    logic [1:0]  b_idx;
    logic        b_halt, b_restart, b_rd_valid, b_ovf;
    logic [31:0] b_rd_pc;
    logic [3:0]  b_rd_cause;
    logic [1:0]  b_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    fault_trap_unit #(.DEPTH(4), .CAUSE_W(4), .CNT_W(8), .HOLD_CYCLES(16), .AUTO_RESTART(0)) u_a (
        .clk(clk), .resetn(a_resetn), .fault_valid(a_fv), .fault_pc(a_pc), .fault_cause(a_cause),
        .clear(a_clear), .rd_idx(a_idx), .halt(a_halt), .restart(a_restart), .rd_valid(a_rd_valid),
        .rd_pc(a_rd_pc), .rd_cause(a_rd_cause), .fault_cnt(a_cnt), .overflow(a_ovf));

    fault_trap_unit #(.DEPTH(4), .CAUSE_W(4), .CNT_W(2), .HOLD_CYCLES(4), .AUTO_RESTART(1)) u_b (
        .clk(clk), .resetn(b_resetn), .fault_valid(b_fv), .fault_pc(b_pc), .fault_cause(b_cause),
        .clear(b_clear), .rd_idx(b_idx), .halt(b_halt), .restart(b_restart), .rd_valid(b_rd_valid),
        .rd_pc(b_rd_pc), .rd_cause(b_rd_cause), .fault_cnt(b_cnt), .overflow(b_ovf));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen_restart, seen_low, seen_high;
        a_resetn = 1'b0; a_fv = 1'b0; a_clear = 1'b0; a_pc = '0; a_cause = '0; a_idx = '0;
        b_resetn = 1'b0; b_fv = 1'b0; b_clear = 1'b0; b_pc = '0; b_cause = '0; b_idx = '0;
        repeat (3) tick();

        // Reset state
        check("rst_a_halt",    32'(a_halt), 0);
        check("rst_a_restart", 32'(a_restart), 0);
        check("rst_a_cnt",     32'(a_cnt), 0);
        check("rst_a_ovf",     32'(a_ovf), 0);
        check("rst_a_rdv",     32'(a_rd_valid), 0);
        check("rst_a_rdpc",    a_rd_pc, 0);
        check("rst_b_halt",    32'(b_halt), 0);
        check("rst_b_cnt",     32'(b_cnt), 0);
        a_resetn = 1'b1; b_resetn = 1'b1;
        repeat (2) tick();

        // Test 1: single fault, hold then park
        a_pc = 32'hBFC00100; a_cause = 4'd3; a_fv = 1'b1; a_idx = 2'd0;
        tick();
        a_fv = 1'b0;
        check("t1_halt_t1",    32'(a_halt), 1);
        check("t1_cnt",        32'(a_cnt), 1);
        check("t1_rdv_pre",    32'(a_rd_valid), 0);
        tick();
        check("t1_rdv",        32'(a_rd_valid), 1);
        check("t1_rdpc",       a_rd_pc, 32'hBFC00100);
        check("t1_rdcause",    32'(a_rd_cause), 3);
        seen_restart = 1'b0; seen_low = 1'b0;
        repeat (40) begin
            tick();
            if (a_restart) seen_restart = 1'b1;
            if (!a_halt)   seen_low = 1'b1;
        end
        check("t1_no_restart", 32'(seen_restart), 0);
        check("t1_halt_held",  32'(seen_low), 0);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("t1_clr_halt",   32'(a_halt), 0);
        check("t1_clr_cnt",    32'(a_cnt), 0);
        tick();
        check("t1_clr_rdv",    32'(a_rd_valid), 0);

        // Test 3: five faults wrap a 4-deep history
        for (int i = 0; i < 5; i++) begin
            a_pc = 32'((i + 1) * 16); a_cause = 4'(i); a_fv = 1'b1;
            tick();
            if (i == 3) check("t3_ovf_after4", 32'(a_ovf), 0);
        end
        a_fv = 1'b0;
        check("t3_cnt",        32'(a_cnt), 5);
        check("t3_ovf",        32'(a_ovf), 1);
        for (int i = 0; i < 4; i++) begin
            a_idx = 2'(i);
            tick();
            check($sformatf("t3_rdpc_%0d", i), a_rd_pc, 32'(80 - 16 * i));
            check($sformatf("t3_rdv_%0d", i),  32'(a_rd_valid), 1);
        end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        tick();

        // Test 5: fault coincident with clear is dropped
        a_clear = 1'b1; a_fv = 1'b1; a_pc = 32'h0000DEAD;
        tick();
        a_clear = 1'b0; a_fv = 1'b0;
        check("t5_cnt",        32'(a_cnt), 0);
        check("t5_halt",       32'(a_halt), 0);
        tick();
        check("t5_halt_later", 32'(a_halt), 0);
        for (int i = 0; i < 4; i++) begin
            a_idx = 2'(i);
            tick();
            check($sformatf("t5_rdv_%0d", i), 32'(a_rd_valid), 0);
        end

        // Test 2: hold 4 then one restart pulse
        b_pc = 32'h00000100; b_cause = 4'd1; b_fv = 1'b1;
        tick();
        b_fv = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t2_halt_t%0d", k),    32'(b_halt), 1);
            check($sformatf("t2_restart_t%0d", k), 32'(b_restart), 0);
            tick();
        end
        check("t2_restart_t5", 32'(b_restart), 1);
        check("t2_halt_t5",    32'(b_halt), 1);
        tick();
        check("t2_halt_t6",    32'(b_halt), 0);
        check("t2_restart_t6", 32'(b_restart), 0);
        tick();
        check("t2_restart_t7", 32'(b_restart), 0);

        // Test 4: 2-bit counter saturates
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_pc = 32'(i); b_fv = 1'b1;
            tick();
            if (i == 2) check("t4_cnt_after3", 32'(b_cnt), 3);
        end
        b_fv = 1'b0;
        check("t4_cnt_sat",    32'(b_cnt), 3);
        check("t4_ovf",        32'(b_ovf), 1);
        repeat (10) tick();
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        tick();

        // Test 6: reset during hold
        b_pc = 32'h00000077; b_fv = 1'b1; b_idx = 2'd0;
        tick();
        b_fv = 1'b0;
        repeat (2) tick();
        check("t6_halt_hold",  32'(b_halt), 1);
        #2 b_resetn = 1'b0;
        #1;
        check("t6_halt_async", 32'(b_halt), 0);
        check("t6_cnt_async",  32'(b_cnt), 0);
        @(posedge clk);
        #1 b_resetn = 1'b1;
        seen_restart = 1'b0; seen_high = 1'b0;
        repeat (20) begin
            tick();
            if (b_restart) seen_restart = 1'b1;
            if (b_halt)    seen_high = 1'b1;
        end
        check("t6_no_restart", 32'(seen_restart), 0);
        check("t6_no_halt",    32'(seen_high), 0);
        check("t6_rdv",        32'(b_rd_valid), 0);
        check("t6_cnt",        32'(b_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fault_trap_unit.md
Name: fault_trap_unit

Overview:
- Parametrised successor to the refcpu error-state stage.
- Instead of silently passing the context through, it records every entry into S_UNKNOWN in a circular history buffer, holds the CPU halted for a programmable window, then either parks the CPU or requests a restart to S_FETCH.
- Sits beside the stage mux; the stage FSM drives fault_valid when ctx.state becomes S_UNKNOWN, and obeys halt/restart.

Parameters:
- DEPTH, 4: history entries; power of two, ≥2.
- CAUSE_W, 4: width of the fault cause code.
- CNT_W, 8: width of the saturating fault counter.
- HOLD_CYCLES, 16: cycles halt is held after a fault; ≥1.
- AUTO_RESTART, 0: 1 = pulse restart after hold; 0 = park in STOP until clear.

Ports:
- clk, input, 1: clock, all state on rising edge.
- resetn, input, 1: asynchronous active-low reset.
- fault_valid, input, 1: one-cycle pulse, CPU entered S_UNKNOWN.
- fault_pc, input, 32: PC of the faulting instruction.
- fault_cause, input, CAUSE_W: cause code, e.g. branch in delay slot.
- clear, input, 1: host clear of history/counter/state.
- rd_idx, input, $clog2(DEPTH): history age index; 0 = most recent.
- halt, output, 1: CPU must not advance.
- restart, output, 1: one-cycle pulse; CPU loads state S_FETCH.
- rd_valid, output, 1: selected entry is occupied.
- rd_pc, output, 32: PC of the selected entry.
- rd_cause, output, CAUSE_W: cause of the selected entry.
- fault_cnt, output, CNT_W: saturating count of recorded faults.
- overflow, output, 1: sticky; an occupied entry was overwritten.

Behaviour:
- Reset (async, resetn=0):
  - FSM = RUN; wr_ptr = 0; all entry valid bits = 0.
  - fault_cnt = 0; overflow = 0; halt = 0; restart = 0.
  - rd_valid = 0; rd_pc = 0; rd_cause = 0; hold timer = 0.
- FSM states:
  - RUN: halt=0. On fault_valid, go to HOLD and load timer = HOLD_CYCLES-1.
  - HOLD: halt=1. Timer decrements each cycle. When timer==0, go to RESTART if AUTO_RESTART=1, else STOP.
  - RESTART: halt=1, restart=1 for exactly one cycle, then RUN.
  - STOP: halt=1. Stays until clear, then RUN.
- halt and restart are registered outputs decoded from the next state. They are visible the cycle after the causing event.
  - Consequence: fault at cycle t gives halt=1 from t+1 through t+HOLD_CYCLES.
  - restart=1 at t+HOLD_CYCLES+1 (AUTO_RESTART=1), halt=0 from t+HOLD_CYCLES+2.
- Recording:
  - Every fault_valid in any state writes {pc, cause} at wr_ptr, sets that entry's valid bit, advances wr_ptr modulo DEPTH, and increments fault_cnt.
  - Faults arriving in HOLD/RESTART/STOP are recorded but do not reload the timer or change the state.
- Wrap: if the entry at wr_ptr is already valid, it is overwritten (the oldest entry) and overflow is set sticky.
- fault_cnt saturates at 2^CNT_W-1; no wrap.
- Readout:
  - Physical slot = (wr_ptr - 1 - rd_idx) mod DEPTH.
  - rd_* are registered, 1-cycle latency from rd_idx.
  - A write and a read in the same cycle: the read returns the pre-write contents.
- clear has priority over everything:
  - Next cycle: FSM=RUN, wr_ptr=0, valid bits=0, fault_cnt=0, overflow=0, halt=0, restart=0.
  - A fault_valid coincident with clear is dropped.
- Reset asserted mid-HOLD/STOP: outputs return immediately (asynchronously) to reset values; no restart pulse is emitted.

Optional Feature:
- Macro FAULT_TRACE_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0) is added.
  - Each recorded fault issues a simulation $display of cycle, PC (hex), cause and slot index.
  - Each overwrite also issues "fault history overflow".
- Undefined: no cycle counter, no display statements. Port list and all port-level behaviour are identical.

Test Plan:
1. Reset, AUTO_RESTART=0, HOLD_CYCLES=16: pulse fault_valid pc=0xBFC00100 cause=3 at t=10 -> halt=1 from t=11, stays 1 past t=40; fault_cnt=1; rd_idx=0 returns valid/0xBFC00100/3 one cycle later; clear -> halt=0 next cycle, fault_cnt=0.
2. AUTO_RESTART=1, HOLD_CYCLES=4: fault at t=5 -> halt 1 at t=6..9; restart=1 only at t=10; halt=0 at t=11.
3. DEPTH=4: five faults pc=0x10,0x20,0x30,0x40,0x50 -> overflow=1; rd_idx 0..3 return 0x50,0x40,0x30,0x20; fault_cnt=5.
4. CNT_W=2: five faults -> fault_cnt stays at 3.
5. clear and fault_valid in the same cycle -> fault dropped: fault_cnt=0, rd_valid=0 for all indices, halt=0.
6. resetn pulsed low during HOLD -> halt=0 immediately; no restart pulse ever follows; history empty.
